// File: rtl/query_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : query_mem_pkg                                                |
// | Description : Macro geometry, column helper and FSM state type shared by   |
// |               the query patch buffer.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package query_mem_pkg;

    localparam int SKY130_MACRO_WIDTH = 32;
    localparam int SKY130_MACRO_DEPTH = 256;
    localparam int SKY130_MACRO_ADDR  = 8;

    // Macros needed side by side to hold a pw-bit word
    function automatic int num_cols(input int pw);
        return (pw + SKY130_MACRO_WIDTH - 1) / SKY130_MACRO_WIDTH;
    endfunction

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } qpb_state_e;

endpackage
`default_nettype wire

// File: rtl/query_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : query_mem_bank                                               |
// | Description : One bank of NUM_COLS SRAM macros side by side sharing chip   |
// |               selects and addresses, padded-width data.                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module query_mem_bank
    import query_mem_pkg::*;
#(
    parameter int NUM_COLS = 2
) (
    input  logic                                   clk,
    input  logic                                   csb0,
    input  logic                                   web0,
    input  logic [SKY130_MACRO_ADDR-1:0]           addr0,
    input  logic [NUM_COLS*SKY130_MACRO_WIDTH-1:0] din0,
    input  logic                                   csb1,
    input  logic [SKY130_MACRO_ADDR-1:0]           addr1,
    output logic [NUM_COLS*SKY130_MACRO_WIDTH-1:0] dout1
);

    localparam int         c_W     = SKY130_MACRO_WIDTH;
    localparam logic [3:0] c_WMASK = 4'hF;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        sky130_sram_1kbyte_1rw1r_32x256_8 u_macro (
            .clk0   (clk),
            .csb0   (csb0),
            .web0   (web0),
            .wmask0 (c_WMASK),
            .addr0  (addr0),
            .din0   (din0[c*c_W +: c_W]),
            .clk1   (clk),
            .csb1   (csb1),
            .addr1  (addr1),
            .dout1  (dout1[c*c_W +: c_W])
        );
    end

endmodule
`default_nettype wire

// File: rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sky130_sram_1kbyte_1rw1r_32x256_8                            |
// | Description : Behavioural stand-in for the 1rw1r 32x256 SRAM macro; port 0 |
// |               write path and port 1 registered read path only.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sky130_sram_1kbyte_1rw1r_32x256_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [7:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] r_mem [256];

    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask0[i]) r_mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
            end
        end
    end

    // Same-edge write on port 0 is not seen here: the read returns old data
    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= r_mem[addr1];
    end

endmodule
`default_nettype wire

// File: rtl/query_patch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : query_patch_buffer                                           |
// | Description : Banked SRAM store for query-image patches: streaming write   |
// |               port with auto-incrementing address, 1-cycle random read.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module query_patch_buffer
    import query_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int PATCH_SIZE  = 5,
    parameter int DEPTH       = 512,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int MACRO_WIDTH = SKY130_MACRO_WIDTH,
    parameter int MACRO_DEPTH = SKY130_MACRO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_clear,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [DATA_WIDTH*PATCH_SIZE-1:0] wr_patch,
    output logic [ADDR_WIDTH:0]              wr_count,
    output logic                             full,
    input  logic                             rd_valid,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic                             rd_data_valid,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] rd_data,
    output logic                             rd_oob
);

    localparam int PW        = DATA_WIDTH * PATCH_SIZE;
    localparam int NUM_COLS  = num_cols(PW);
    localparam int NUM_BANKS = DEPTH / MACRO_DEPTH;
    localparam int c_PAD_W   = NUM_COLS * MACRO_WIDTH;
    localparam int c_BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [ADDR_WIDTH:0] c_CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    qpb_state_e                   r_state, w_state_nxt;
    logic                         r_live;
    logic [ADDR_WIDTH:0]          r_wr_count;
    logic                         w_wr_ready, w_wr_fire;
    logic [ADDR_WIDTH-1:0]        w_wr_addr;
    logic [c_BANK_W-1:0]          w_wr_bank, w_rd_bank, r_rd_sel;
    logic [SKY130_MACRO_ADDR-1:0] w_wr_row, w_rd_row;
    logic [c_PAD_W-1:0]           w_wr_din, w_sel_dout;
    logic [c_PAD_W-1:0]           w_bank_dout [NUM_BANKS];
    logic                         r_rd_valid, r_rd_oob, r_rd_seen;

    // r_live keeps wr_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_live     <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (wr_clear)       r_wr_count <= '0;
            else if (w_wr_fire) r_wr_count <= r_wr_count + (ADDR_WIDTH+1)'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_wr_fire   = 1'b0;
        case (r_state)
            LOAD:    w_wr_ready = r_live;
            FULL:    w_wr_ready = 1'b0;
            default: w_state_nxt = LOAD;
        endcase
        w_wr_fire = w_wr_ready && wr_valid && !wr_clear;
        if (w_wr_fire && (r_wr_count == c_CNT_LAST)) w_state_nxt = FULL;
        if (wr_clear) w_state_nxt = LOAD;
    end

    assign w_wr_addr = r_wr_count[ADDR_WIDTH-1:0];
    assign w_wr_bank = c_BANK_W'(32'(w_wr_addr) / MACRO_DEPTH);
    assign w_wr_row  = SKY130_MACRO_ADDR'(32'(w_wr_addr) % MACRO_DEPTH);
    assign w_rd_bank = c_BANK_W'(32'(rd_addr) / MACRO_DEPTH);
    assign w_rd_row  = SKY130_MACRO_ADDR'(32'(rd_addr) % MACRO_DEPTH);
    assign w_wr_din  = c_PAD_W'(wr_patch);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_csb0, w_csb1;
        assign w_csb0 = !(w_wr_fire && (w_wr_bank == c_BANK_W'(b)));
        assign w_csb1 = !(rd_valid && (w_rd_bank == c_BANK_W'(b)));

        query_mem_bank #(.NUM_COLS(NUM_COLS)) u_bank (
            .clk   (clk),
            .csb0  (w_csb0),
            .web0  (w_csb0),
            .addr0 (w_wr_row),
            .din0  (w_wr_din),
            .csb1  (w_csb1),
            .addr1 (w_rd_row),
            .dout1 (w_bank_dout[b])
        );
    end

    // Bank select travels with the request to line up with macro read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rd_sel   <= '0;
        end else begin
            r_rd_valid <= rd_valid;
            r_rd_oob   <= rd_valid && ({1'b0, rd_addr} >= r_wr_count);
            if (rd_valid) begin
                r_rd_seen <= 1'b1;
                r_rd_sel  <= w_rd_bank;
            end
        end
    end

    assign w_sel_dout = w_bank_dout[r_rd_sel];

    if (c_PAD_W > PW) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^w_sel_dout[c_PAD_W-1:PW];
    end

    // Macro outputs are not reset, so rd_data is forced to 0 until a read lands
    assign rd_data       = r_rd_seen ? w_sel_dout[PW-1:0] : '0;
    assign rd_data_valid = r_rd_valid;
    assign rd_oob        = r_rd_oob;
    assign wr_ready      = w_wr_ready;
    assign wr_count      = r_wr_count;
    assign full          = (r_wr_count == c_CNT_FULL);

endmodule
`default_nettype wire

// File: tb/tb_query_patch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_query_patch_buffer                                        |
// | Description : Self-checking bench for two query_patch_buffer configs.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_query_patch_buffer;

    localparam int A_AW = 9;
    localparam int A_PW = 55;
    localparam int B_AW = 10;
    localparam int B_PW = 72;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            wr_clear_a = 0, wr_valid_a = 0, rd_valid_a = 0;
    logic [A_PW-1:0] wr_patch_a = '0;
    logic [A_AW-1:0] rd_addr_a  = '0;
    logic            wr_ready_a, full_a, rd_data_valid_a, rd_oob_a;
    logic [A_AW:0]   wr_count_a;
    logic [A_PW-1:0] rd_data_a;

    logic            wr_clear_b = 0, wr_valid_b = 0, rd_valid_b = 0;
    logic [B_PW-1:0] wr_patch_b = '0;
    logic [B_AW-1:0] rd_addr_b  = '0;
    logic            wr_ready_b, full_b, rd_data_valid_b, rd_oob_b;
    logic [B_AW:0]   wr_count_b;
    logic [B_PW-1:0] rd_data_b;

    query_patch_buffer #(.DATA_WIDTH(11), .PATCH_SIZE(5), .DEPTH(512)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_clear(wr_clear_a), .wr_valid(wr_valid_a),
        .wr_ready(wr_ready_a), .wr_patch(wr_patch_a), .wr_count(wr_count_a), .full(full_a),
        .rd_valid(rd_valid_a), .rd_addr(rd_addr_a), .rd_data_valid(rd_data_valid_a),
        .rd_data(rd_data_a), .rd_oob(rd_oob_a)
    );

    query_patch_buffer #(.DATA_WIDTH(8), .PATCH_SIZE(9), .DEPTH(1024)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_clear(wr_clear_b), .wr_valid(wr_valid_b),
        .wr_ready(wr_ready_b), .wr_patch(wr_patch_b), .wr_count(wr_count_b), .full(full_b),
        .rd_valid(rd_valid_b), .rd_addr(rd_addr_b), .rd_data_valid(rd_data_valid_b),
        .rd_data(rd_data_b), .rd_oob(rd_oob_b)
    );

    typedef struct { logic [71:0] data; logic oob; int cyc; } exp_t;
    typedef struct { logic [A_AW-1:0] addr; logic [A_PW-1:0] data; logic oob; } rd_vec_t;

    exp_t    qa[$];
    exp_t    qb[$];
    rd_vec_t vecs [6];
    int      baddr [6];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [A_AW-1:0] addr, input logic [A_PW-1:0] data, input logic oob);
        exp_t e;
        e.data = 72'(data);
        e.oob  = oob;
        e.cyc  = cyc + 1;
        qa.push_back(e);
        rd_valid_a = 1'b1;
        rd_addr_a  = addr;
    endtask

    task automatic rd_b(input logic [B_AW-1:0] addr, input logic [B_PW-1:0] data, input logic oob);
        exp_t e;
        e.data = data;
        e.oob  = oob;
        e.cyc  = cyc + 1;
        qb.push_back(e);
        rd_valid_b = 1'b1;
        rd_addr_b  = addr;
    endtask

    function automatic logic [B_PW-1:0] pat_b(input int i);
        return {8'h80 | 8'(i), 32'hDEAD_BEEF ^ 32'(i), 32'h1234_5678 + 32'(i)};
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rd_data_valid_a) begin
            if (qa.size() == 0) begin
                check("rd_a_unexpected_valid", 72'(rd_data_valid_a), 72'(0));
            end else begin
                e = qa.pop_front();
                check("rd_a_latency", 72'(cyc), 72'(e.cyc));
                check("rd_a_data", 72'(rd_data_a), e.data);
                check("rd_a_oob", 72'(rd_oob_a), 72'(e.oob));
            end
        end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
            check("rd_a_missing_valid", 72'(rd_data_valid_a), 72'(1));
            qa.delete(0);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rd_data_valid_b) begin
            if (qb.size() == 0) begin
                check("rd_b_unexpected_valid", 72'(rd_data_valid_b), 72'(0));
            end else begin
                e = qb.pop_front();
                check("rd_b_latency", 72'(cyc), 72'(e.cyc));
                check("rd_b_data", rd_data_b, e.data);
                check("rd_b_oob", 72'(rd_oob_b), 72'(e.oob));
            end
        end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
            check("rd_b_missing_valid", 72'(rd_data_valid_b), 72'(1));
            qb.delete(0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{addr: 9'd0,   data: 55'd0,    oob: 1'b0};
        vecs[1] = '{addr: 9'd255, data: 55'd765,  oob: 1'b0};
        vecs[2] = '{addr: 9'd256, data: 55'd768,  oob: 1'b0};
        vecs[3] = '{addr: 9'd511, data: 55'd1533, oob: 1'b0};
        vecs[4] = '{addr: 9'd300, data: 55'd900,  oob: 1'b0};
        vecs[5] = '{addr: 9'd44,  data: 55'd132,  oob: 1'b0};
        baddr   = '{1023, 0, 255, 256, 767, 768};

        // Reset values
        tick(); tick();
        check("rst_wr_ready_a", 72'(wr_ready_a), 72'(0));
        check("rst_wr_ready_b", 72'(wr_ready_b), 72'(0));
        check("rst_wr_count_a", 72'(wr_count_a), 72'(0));
        check("rst_full_a", 72'(full_a), 72'(0));
        check("rst_rd_valid_a", 72'(rd_data_valid_a), 72'(0));
        check("rst_rd_data_a", 72'(rd_data_a), 72'(0));
        check("rst_rd_oob_a", 72'(rd_oob_a), 72'(0));
        rst_n = 1'b1;
        tick();
        check("post_rst_wr_ready_a", 72'(wr_ready_a), 72'(1));

        // Fill all 512 patches
        for (int i = 0; i < 512; i++) begin
            wr_valid_a = 1'b1;
            wr_patch_a = 55'(i * 3);
            check("fill_wr_ready_a", 72'(wr_ready_a), 72'(1));
            tick();
        end
        wr_patch_a = 55'h7FF;
        check("fill_count_a", 72'(wr_count_a), 72'(512));
        check("fill_full_a", 72'(full_a), 72'(1));
        check("fill_ready_low_a", 72'(wr_ready_a), 72'(0));
        tick();
        wr_valid_a = 1'b0;
        check("extra_write_count_a", 72'(wr_count_a), 72'(512));

        // Back-to-back reads across the bank boundary
        for (int i = 0; i < 6; i++) begin
            rd_a(vecs[i].addr, vecs[i].data, vecs[i].oob);
            tick();
        end
        rd_valid_a = 1'b0;
        tick();
        check("hold_valid_low_a", 72'(rd_data_valid_a), 72'(0));
        check("hold_data_a", 72'(rd_data_a), 72'(vecs[5].data));

        // Clear with a write offered while full
        wr_clear_a = 1'b1; wr_valid_a = 1'b1; wr_patch_a = 55'h1AB;
        tick();
        wr_clear_a = 1'b0; wr_valid_a = 1'b0;
        check("clear_count_a", 72'(wr_count_a), 72'(0));
        check("clear_full_a", 72'(full_a), 72'(0));
        check("clear_ready_a", 72'(wr_ready_a), 72'(1));
        rd_a(9'd0, 55'd0, 1'b1);
        tick();
        rd_valid_a = 1'b0;

        // Refill 10 patches, first one lands at address 0
        wr_valid_a = 1'b1; wr_patch_a = 55'h123;
        tick();
        for (int i = 1; i < 10; i++) begin
            wr_patch_a = 55'(i * 3);
            tick();
        end
        wr_valid_a = 1'b0;
        check("refill_count_a", 72'(wr_count_a), 72'(10));
        rd_a(9'd10, 55'd30, 1'b1);   tick();
        rd_a(9'd9,  55'd27, 1'b0);   tick();
        rd_a(9'd0,  55'h123, 1'b0);  tick();
        rd_valid_a = 1'b0;
        tick();

        // Clear and write together in LOAD: write dropped
        wr_clear_a = 1'b1; wr_valid_a = 1'b1; wr_patch_a = 55'h555;
        tick();
        wr_clear_a = 1'b0; wr_valid_a = 1'b0;
        check("clear_drop_count_a", 72'(wr_count_a), 72'(0));
        rd_a(9'd10, 55'd30, 1'b1);
        tick();
        rd_valid_a = 1'b0;

        // Same-cycle write and read of address 5
        for (int i = 0; i < 5; i++) begin
            wr_valid_a = 1'b1;
            wr_patch_a = 55'(i * 3);
            tick();
        end
        wr_patch_a = 55'h7FF;
        rd_a(9'd5, 55'd15, 1'b1);
        tick();
        wr_valid_a = 1'b0;
        rd_a(9'd5, 55'h7FF, 1'b0);
        tick();
        rd_valid_a = 1'b0;
        tick();
        check("rw_same_count_a", 72'(wr_count_a), 72'(6));

        // Asynchronous reset with a read in flight
        rd_valid_a = 1'b1; rd_addr_a = 9'd3;
        tick();
        rd_valid_a = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_a", 72'(rd_data_valid_a), 72'(0));
        check("async_rst_count_a", 72'(wr_count_a), 72'(0));
        check("async_rst_data_a", 72'(rd_data_a), 72'(0));
        check("async_rst_oob_a", 72'(rd_oob_a), 72'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("rerelease_ready_a", 72'(wr_ready_a), 72'(1));
        wr_valid_a = 1'b1; wr_patch_a = 55'h3C5;
        tick();
        wr_valid_a = 1'b0;
        rd_a(9'd0, 55'h3C5, 1'b0);
        tick();
        rd_valid_a = 1'b0;
        tick();

        // Wide configuration: 72-bit patches, 3 columns, 4 banks
        for (int i = 0; i < 1024; i++) begin
            wr_valid_b = 1'b1;
            wr_patch_b = pat_b(i);
            tick();
        end
        wr_valid_b = 1'b0;
        check("fill_count_b", 72'(wr_count_b), 72'(1024));
        check("fill_full_b", 72'(full_b), 72'(1));
        for (int i = 0; i < 6; i++) begin
            rd_b(B_AW'(baddr[i]), pat_b(baddr[i]), 1'b0);
            tick();
        end
        rd_valid_b = 1'b0;
        tick(); tick();

        check("scoreboard_a_drained", 72'(qa.size()), 72'(0));
        check("scoreboard_b_drained", 72'(qb.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/query_patch_buffer.md
Name: query_patch_buffer

Overview:
Parametrised banked store for query-image patches, built from sky130 1rw1r 32x256 SRAM macros. Patches stream in from I/O over a valid/ready write port. An internal write counter places each patch at the next address. Compute reads any stored patch by address through port 1 and receives the full-width patch one cycle later. The bank-select is registered so the read mux is aligned with the macro read latency.

Parameters:
DATA_WIDTH, 11, bits per pixel element
PATCH_SIZE, 5, elements per patch
DEPTH, 512, patches stored; must be a multiple of MACRO_DEPTH
ADDR_WIDTH, $clog2(DEPTH), patch address width
MACRO_WIDTH, 32, macro data width (fixed by macro)
MACRO_DEPTH, 256, macro words (fixed by macro)
Derived (localparam): PW = DATA_WIDTH*PATCH_SIZE; NUM_COLS = ceil(PW/MACRO_WIDTH); NUM_BANKS = DEPTH/MACRO_DEPTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_clear  in  1  synchronous pulse: discard contents, write counter back to 0
wr_valid  in  1  write patch offered
wr_ready  out  1  buffer can accept a patch (not full)
wr_patch  in  PW  patch data, element 0 in LSBs
wr_count  out  ADDR_WIDTH+1  number of patches stored
full  out  1  wr_count == DEPTH
rd_valid  in  1  read request
rd_addr  in  ADDR_WIDTH  patch address to read
rd_data_valid  out  1  rd_data valid this cycle
rd_data  out  PW  patch read
rd_oob  out  1  with rd_data_valid: requested address was >= wr_count at request time

Behaviour:
- Reset (rst_n low, async): state=LOAD, wr_count=0, full=0, wr_ready=0 while rst_n is low and 1 after release, rd_data_valid=0, rd_data=0, rd_oob=0. SRAM contents are undefined after reset.
- FSM states: LOAD and FULL.
  - LOAD: wr_ready=1. A write is accepted when wr_valid & wr_ready.
  - LOAD -> FULL when an accepted write makes wr_count == DEPTH.
  - FULL: wr_ready=0. wr_valid is ignored, with no counter change and no macro write.
  - Any state -> LOAD on wr_clear; wr_count=0 on the next edge.
- wr_clear and an accepted write in the same cycle: clear wins and the write is dropped (web stays high).
- Write address = wr_count[ADDR_WIDTH-1:0].
  - Bank = addr / MACRO_DEPTH; row = addr % MACRO_DEPTH.
  - Only the addressed bank's macros get csb0=0, web0=0, wmask0 all ones.
  - wr_patch is zero-padded to NUM_COLS*MACRO_WIDTH; column c receives bits [32c+31:32c].
  - Unwritten banks keep csb0=1 (power).
- Reads use macro port 1 only. On rd_valid, only the addressed bank gets csb1=0.
  - The bank index is registered alongside the request.
  - Next cycle: rd_data_valid=1, and rd_data = the selected bank's concatenated dout1, truncated to PW.
  - Latency is fixed at 1 cycle. Throughput is one read per cycle with no backpressure.
- rd_data holds its last value while rd_data_valid=0. It is muxed from the registered select, never from the live rd_addr.
- Read and write to the same address in the same cycle: the read returns old data. rd_oob is 1 if the address >= wr_count before the write.
- rd_oob is computed from the pre-edge wr_count and registered with the request. Data is still returned.
- Reads are unaffected by wr_clear except through rd_oob.
- Async reset mid-operation: all state is cleared immediately. A read in flight produces no rd_data_valid.

Decomposition:
- Package query_mem_pkg holds:
  - SKY130_MACRO_WIDTH=32, SKY130_MACRO_DEPTH=256, SKY130_MACRO_ADDR=8
  - function num_cols(pw)
  - typedef qpb_state_e {LOAD, FULL}
- Sub-module query_mem_bank: one bank of NUM_COLS macros side by side, with shared csb/web/addr and width-padded din/dout. It is instantiated NUM_BANKS times in a generate loop.
- Bank select decode, counter, FSM and the output mux stay in the top.

Test Plan:
- Reset then 512 writes of patch = i*3 (wr_valid held high) -> wr_ready=1 for 512 cycles. wr_count hits 512, full=1, wr_ready=0. A 513th wr_valid changes nothing.
- Read addrs 0, 255, 256, 511 back-to-back -> rd_data_valid on cycles 1 to 4 with data 0, 765, 768, 1533. rd_oob=0. This checks the bank crossing with the registered select.
- After 10 writes, read addr 10 then addr 9 -> first response rd_oob=1, second rd_oob=0 with data 27.
- Same-cycle write addr 5 (new value 0x7FF) and read addr 5, where the old value is 15 -> rd_data=15. A read one cycle later returns 0x7FF.
- wr_clear together with wr_valid while FULL -> wr_count=0, state LOAD, no macro write. The next write lands at addr 0.
- Assert rst_n=0 while a read is in flight -> rd_data_valid stays 0 and wr_count=0 immediately. Release, then write and read addr 0 -> correct data.
- Run the regression also with DATA_WIDTH=8, PATCH_SIZE=9, DEPTH=1024 (NUM_COLS=3, NUM_BANKS=4): write a pattern with the MSB element set, read addr 1023 -> all 72 bits match and padding is never visible.
